// File: rtl/refill_pkg.sv
// Shared types and width helpers for the cache line refill engine.
// Width constants are derived from the default geometry; the helper
// functions derive the same widths for any parameterisation.
package refill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } refill_state_t;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_WORDS_PER_LINE = 8;
    localparam int DEF_SETS           = 128;

    // Width of a field that must index n entries (never narrower than 1 bit).
    function automatic int field_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int index_w(input int sets);
        return field_w(sets);
    endfunction

    function automatic int offset_w(input int words_per_line);
        return field_w(words_per_line);
    endfunction

    function automatic int ram_addr_w(input int sets, input int words_per_line);
        return index_w(sets) + offset_w(words_per_line);
    endfunction

    localparam int INDEX_W    = index_w(DEF_SETS);
    localparam int OFFSET_W   = offset_w(DEF_WORDS_PER_LINE);
    localparam int RAM_ADDR_W = ram_addr_w(DEF_SETS, DEF_WORDS_PER_LINE);

endpackage

// File: rtl/cache_line_refill_if.sv
// Bus bundle for the refill engine: miss request, memory burst request,
// read-beat channel, data-RAM write port, and status/forward outputs.
// The slave modport is the refill engine's view; master is its environment.
interface cache_line_refill_if
    import refill_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int SETS           = DEF_SETS
);
    localparam int IW = index_w(SETS);
    localparam int OW = offset_w(WORDS_PER_LINE);
    localparam int AW = ram_addr_w(SETS, WORDS_PER_LINE);

    logic                  req_valid;
    logic                  req_ready;
    logic [IW-1:0]         req_index;
    logic [OW-1:0]         req_offset;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [IW-1:0]         mem_req_index;
    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic                  ram_en;
    logic                  ram_we;
    logic [AW-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic                  done;
    logic                  err;
    logic                  busy;
    logic                  fwd_valid;
    logic [DATA_WIDTH-1:0] fwd_data;

    modport slave (
        input  req_valid, req_index, req_offset, mem_req_ready,
               r_valid, r_data, r_last,
        output req_ready, mem_req_valid, mem_req_index, r_ready,
               ram_en, ram_we, ram_addr, ram_din,
               done, err, busy, fwd_valid, fwd_data
    );

    modport master (
        output req_valid, req_index, req_offset, mem_req_ready,
               r_valid, r_data, r_last,
        input  req_ready, mem_req_valid, mem_req_index, r_ready,
               ram_en, ram_we, ram_addr, ram_din,
               done, err, busy, fwd_valid, fwd_data
    );

endinterface

// File: rtl/cache_line_refill.sv
// Cache line refill engine: accepts a miss, issues one burst read, writes
// every returned beat into the external data RAM at {index, beat_cnt} and
// pulses done when the line is complete. Reset (rst) is synchronous and
// active-low; every output is forced to 0 while it is asserted.
// Optional feature macro: REFILL_FORWARD_EN (critical-word forward).
module cache_line_refill
    import refill_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int SETS           = DEF_SETS
)(
    input  logic               clk,
    input  logic               rst,
    cache_line_refill_if.slave bus
);
    localparam int IW = index_w(SETS);
    localparam int OW = offset_w(WORDS_PER_LINE);

    refill_state_t state_reg;
    refill_state_t state_next;

    logic [IW-1:0] index_reg;
    logic [OW-1:0] beat_cnt_reg;
    logic          err_reg;
    logic          beat_fire;
    logic          last_beat;
    logic          req_take;

    // beat_cnt is exactly log2(WORDS_PER_LINE) bits, so the final beat is all ones
    assign last_beat = &beat_cnt_reg;

    // Next-state logic and beat/request acceptance strobes
    always_comb begin
        state_next = state_reg;
        beat_fire  = 1'b0;
        req_take   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    req_take   = 1'b1;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (bus.mem_req_ready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bus.r_valid) begin
                    beat_fire = 1'b1;
                    if (last_beat) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request latch, beat counter and sticky r_last mismatch flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            index_reg    <= '0;
            beat_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (req_take) begin
                index_reg    <= bus.req_index;
                beat_cnt_reg <= '0;
                err_reg      <= 1'b0;
            end
            if (beat_fire) begin
                // The count alone ends the line; r_last only flags disagreement
                beat_cnt_reg <= beat_cnt_reg + 1'b1;
                if (bus.r_last != last_beat) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready     = rst && (state_reg == IDLE);
    assign bus.mem_req_valid = rst && (state_reg == ADDR);
    assign bus.mem_req_index = rst ? index_reg : '0;
    assign bus.r_ready       = rst && (state_reg == DATA);
    assign bus.ram_en        = rst && beat_fire;
    assign bus.ram_we        = rst && beat_fire;
    assign bus.ram_addr      = rst ? {index_reg, beat_cnt_reg} : '0;
    assign bus.ram_din       = rst ? bus.r_data : '0;
    assign bus.done          = rst && (state_reg == DONE);
    assign bus.err           = rst && err_reg;
    assign bus.busy          = rst && (state_reg != IDLE);

`ifdef REFILL_FORWARD_EN
    logic [OW-1:0]         offset_reg;
    logic                  fwd_valid_reg;
    logic [DATA_WIDTH-1:0] fwd_data_reg;

    // Capture the critical word as it streams past; fwd_valid follows one cycle later
    always_ff @(posedge clk) begin
        if (!rst) begin
            offset_reg    <= '0;
            fwd_valid_reg <= 1'b0;
            fwd_data_reg  <= '0;
        end else begin
            if (req_take) begin
                offset_reg <= bus.req_offset;
            end
            fwd_valid_reg <= beat_fire && (beat_cnt_reg == offset_reg);
            if (beat_fire && (beat_cnt_reg == offset_reg)) begin
                fwd_data_reg <= bus.r_data;
            end
        end
    end

    assign bus.fwd_valid = rst && fwd_valid_reg;
    assign bus.fwd_data  = rst ? fwd_data_reg : '0;
`else
    // Critical word number is only meaningful when forwarding is built in
    logic unused_offset;
    assign unused_offset = ^bus.req_offset;

    assign bus.fwd_valid = 1'b0;
    assign bus.fwd_data  = '0;
`endif

endmodule
